// File: rtl/dpwm_ramp_gen_pkg.sv
// Shared types and constants for the DPWM carrier ramp generator.
package ramp_pkg;

    localparam int unsigned RAMP_W = 11;

    typedef logic [RAMP_W-1:0] ramp_t;

    localparam ramp_t PERIOD_MIN          = ramp_t'(2);
    localparam ramp_t RAMP_PERIOD_DEFAULT = ramp_t'(1000);

    // Periods below PERIOD_MIN would leave no room for a ramp.
    function automatic ramp_t clamp_period(input ramp_t p);
        return (p < PERIOD_MIN) ? PERIOD_MIN : p;
    endfunction

endpackage

// File: rtl/dpwm_ramp_gen_if.sv
// Control/carrier bundle between the ramp generator and its controller/comparators.
interface dpwm_ramp_gen_if;
    import ramp_pkg::*;

    logic  en;
    ramp_t period;
    ramp_t shift;
    logic  shift_en;
    logic  sync_in;
    ramp_t ramp_ref;
    ramp_t ramp_ref_s;
    logic  shflag;
    logic  sync_out;

    modport master (
        output en, period, shift, shift_en, sync_in,
        input  ramp_ref, ramp_ref_s, shflag, sync_out
    );

    modport slave (
        input  en, period, shift, shift_en, sync_in,
        output ramp_ref, ramp_ref_s, shflag, sync_out
    );

endinterface

// File: rtl/dpwm_ramp_gen_mod_add.sv
// Combinational (a + b) mod m, valid only when both a and b are below m.
module ramp_mod_add
    import ramp_pkg::*;
(
    input  ramp_t i_a,
    input  ramp_t i_b,
    input  ramp_t i_mod,
    output ramp_t o_sum
);

    logic [RAMP_W:0] w_sum;
    logic [RAMP_W:0] w_wrapped;

    // Operands below the modulus keep the sum under 2*m, so one subtraction suffices.
    always_comb begin
        w_sum     = {1'b0, i_a} + {1'b0, i_b};
        w_wrapped = w_sum - {1'b0, i_mod};
        o_sum     = (w_sum >= {1'b0, i_mod}) ? w_wrapped[RAMP_W-1:0] : w_sum[RAMP_W-1:0];
    end

endmodule

// File: rtl/dpwm_ramp_gen.sv
// Sawtooth carrier with shadowed period/shift, phase-shifted copy and period-start sync pulse.
module dpwm_ramp_gen
    import ramp_pkg::*;
#(
    parameter ramp_t PERIOD_DEFAULT = RAMP_PERIOD_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dpwm_ramp_gen_if.slave bus
);

    ramp_t r_cnt;
    ramp_t r_period_act;
    ramp_t r_shift_act;
    logic  r_shflag;
    ramp_t r_ramp_ref_s;
    logic  r_sync_out;

    logic  w_boundary;
    ramp_t w_period_new;
    ramp_t w_shift_new;
    ramp_t w_cnt_next;
    ramp_t w_period_next;
    ramp_t w_shift_next;
    logic  w_shflag_next;
    ramp_t w_ramp_s_next;

    // sync_in overrides en so an external resync always restarts with fresh shadows.
    always_comb begin
        w_boundary    = (bus.en && (r_cnt == r_period_act - 1'b1)) || bus.sync_in;
        w_period_new  = clamp_period(bus.period);
        w_shift_new   = (bus.shift < w_period_new) ? bus.shift : '0;
        w_cnt_next    = r_cnt;
        w_period_next = r_period_act;
        w_shift_next  = r_shift_act;
        w_shflag_next = r_shflag;
        if (w_boundary) begin
            w_cnt_next    = '0;
            w_period_next = w_period_new;
            w_shift_next  = w_shift_new;
            w_shflag_next = bus.shift_en;
        end else if (bus.en) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Shifted ramp is built from next-state values so both ramps move on the same edge.
    ramp_mod_add u_mod_add (
        .i_a   (w_cnt_next),
        .i_b   (w_shift_next),
        .i_mod (w_period_next),
        .o_sum (w_ramp_s_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_period_act <= PERIOD_DEFAULT;
            r_shift_act  <= '0;
            r_shflag     <= 1'b0;
            r_ramp_ref_s <= '0;
            r_sync_out   <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_period_act <= w_period_next;
            r_shift_act  <= w_shift_next;
            r_shflag     <= w_shflag_next;
            r_ramp_ref_s <= w_ramp_s_next;
            r_sync_out   <= w_boundary;
        end
    end

    assign bus.ramp_ref   = r_cnt;
    assign bus.ramp_ref_s = r_ramp_ref_s;
    assign bus.shflag     = r_shflag;
    assign bus.sync_out   = r_sync_out;

endmodule

// File: tb/tb_dpwm_ramp_gen.sv
// Directed self-checking bench for dpwm_ramp_gen.
module tb_dpwm_ramp_gen;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   er;
    int   es;
    logic ef;
    logic ey;

    dpwm_ramp_gen_if u_if ();

    dpwm_ramp_gen u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        u_if.en = 1'b0; u_if.period = 11'd8; u_if.shift = 11'd0;
        u_if.shift_en = 1'b0; u_if.sync_in = 1'b0;
        step(); step();
        er = 0; es = 0; ef = 1'b0; ey = 1'b0;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL reset: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
        rst = 1'b0;
        u_if.sync_in = 1'b1;
        step();
        er = 0; es = 0; ef = 1'b0; ey = 1'b1;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL initial_sync: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
        u_if.sync_in = 1'b0;
        u_if.en = 1'b1;
    endtask

    task automatic test_basic;
        for (int k = 1; k <= 16; k++) begin
            step();
            er = k % 8; es = er; ef = 1'b0; ey = (er == 0);
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL basic step %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
    endtask

    task automatic test_shift;
        for (int k = 1; k <= 7; k++) begin
            if (k == 4) begin
                u_if.shift = 11'd3;
                u_if.shift_en = 1'b1;
            end
            step();
            er = k; es = k; ef = 1'b0; ey = 1'b0;
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL shift_pending step %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
        for (int k = 0; k <= 7; k++) begin
            step();
            er = k; es = (k + 3) % 8; ef = 1'b1; ey = (k == 0);
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL shift_active step %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
    endtask

    task automatic test_clamp;
        u_if.shift = 11'd9;
        for (int k = 0; k <= 7; k++) begin
            step();
            er = k; es = k; ef = 1'b1; ey = (k == 0);
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL shift_oob step %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
        u_if.period = 11'd1;
        for (int k = 0; k <= 3; k++) begin
            step();
            er = k % 2; es = er; ef = 1'b1; ey = (er == 0);
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL period_min step %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
        u_if.period = 11'd8;
        u_if.shift = 11'd2;
        step();
        er = 0; es = 2; ef = 1'b1; ey = 1'b1;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL reload_8: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
    endtask

    task automatic test_sync;
        // Entries: sync_in driven before the edge, then expected ramp_ref after it.
        int sync_v[19] = '{0,0,0,0,0, 1, 0,0,0,0,0,0,0, 1, 0, 1,1,1, 0};
        int ramp_v[19] = '{1,2,3,4,5, 0, 1,2,3,4,5,6,7, 0, 1, 0,0,0, 1};
        for (int k = 0; k < 19; k++) begin
            u_if.sync_in = sync_v[k][0];
            step();
            er = ramp_v[k]; es = (er + 2) % 8; ef = 1'b1; ey = sync_v[k][0] || (k == 6 && 1'b0);
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL sync vec %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
        u_if.sync_in = 1'b0;
    endtask

    task automatic test_en_low;
        for (int k = 2; k <= 4; k++) step();
        u_if.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            er = 4; es = 6; ef = 1'b1; ey = 1'b0;
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL en_low cycle %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
        u_if.en = 1'b1;
        step();
        er = 5; es = 7; ef = 1'b1; ey = 1'b0;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL en_resume: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
        u_if.en = 1'b0;
        u_if.sync_in = 1'b1;
        step();
        er = 0; es = 2; ef = 1'b1; ey = 1'b1;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL sync_en_low: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
        u_if.sync_in = 1'b0;
        step();
        er = 0; es = 2; ef = 1'b1; ey = 1'b0;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL hold_after_sync: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
        u_if.en = 1'b1;
        step();
    endtask

    task automatic test_reset_mid;
        for (int k = 2; k <= 6; k++) step();
        #2 rst = 1'b1;
        #1;
        er = 0; es = 0; ef = 1'b0; ey = 1'b0;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL async_reset: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 999; k++) begin
            step();
            er = k; es = k; ef = 1'b0; ey = 1'b0;
            n_checks++;
            if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
                n_errors++;
                $display("FAIL default_period step %0d: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                         k, u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
            end
        end
        step();
        er = 0; es = 2; ef = 1'b1; ey = 1'b1;
        n_checks++;
        if (u_if.ramp_ref !== 11'(er) || u_if.ramp_ref_s !== 11'(es) || u_if.shflag !== ef || u_if.sync_out !== ey) begin
            n_errors++;
            $display("FAIL wrap_999: got %0d %0d %0b %0b, expected %0d %0d %0b %0b",
                     u_if.ramp_ref, u_if.ramp_ref_s, u_if.shflag, u_if.sync_out, er, es, ef, ey);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_shift();
        test_clamp();
        test_sync();
        test_en_low();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
